// File: rtl/if_id_pipeline_ctrl_pkg.sv
// if_id_pipeline_ctrl_pkg: shared decode fields, FSM states and NOP word for the IF/ID front end
package if_id_pipeline_ctrl_pkg;
  localparam logic [2:0] ICMD_DP_REG = 3'b000;
  localparam logic [2:0] ICMD_DP_IMM = 3'b001;
  localparam logic [2:0] ICMD_LS_REG = 3'b011;
  localparam logic [2:0] ICMD_BRANCH = 3'b101;
  localparam int ICMD_LSB = 25;
  localparam int RN_LSB = 16;
  localparam int RM_LSB = 0;
  localparam int RD_LSB = 12;
  localparam int L_BIT = 20;
  localparam int S_BIT = 20;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;
endpackage

// File: rtl/if_id_pipeline_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count
);
  // count events, hold once every bit is set
  always_ff @(posedge clk)
    count <= reset ? '0 : (inc && !(&count)) ? count + 1'b1 : count;
endmodule

// File: rtl/if_id_pipeline_ctrl.sv
// if_id_pipeline_ctrl: IF/ID register with load-use stall, branch flush and event counters
module if_id_pipeline_ctrl
  import if_id_pipeline_ctrl_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    COUNT_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD    = NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  IF_PC,
  input  logic [DATA_WIDTH-1:0]  IF_instruction,
  input  logic [3:0]             EXE_Rd_num,
  input  logic                   EXE_load_instr,
  input  logic                   EXE_RF_enable,
  input  logic                   branch_taken,
  output logic [DATA_WIDTH-1:0]  ID_instruction,
  output logic [DATA_WIDTH-1:0]  ID_PC,
  output logic                   ID_valid,
  output logic                   PC_enable,
  output logic                   ID_bubble,
  output logic [COUNT_WIDTH-1:0] stall_count,
  output logic [COUNT_WIDTH-1:0] flush_count
);
  state_t state, state_nxt;
  logic [2:0] icmd;
  logic rn_hit, rm_hit, rd_hit, hazard, stall, flush;
  assign icmd = ID_instruction[ICMD_LSB +: 3];
  assign rn_hit = icmd != ICMD_BRANCH && EXE_Rd_num == ID_instruction[RN_LSB +: 4];
  assign rm_hit = (icmd == ICMD_DP_REG || icmd == ICMD_LS_REG) && EXE_Rd_num == ID_instruction[RM_LSB +: 4];
  assign rd_hit = icmd[2:1] == 2'b01 && !ID_instruction[L_BIT] && EXE_Rd_num == ID_instruction[RD_LSB +: 4];
  assign hazard = ID_valid && EXE_load_instr && EXE_RF_enable && (rn_hit || rm_hit || rd_hit);
  // the STALL state masks the hazard: EXE then holds the bubble and MEM forwarding covers the load
  always_comb begin
    stall = !reset && state == RUN && hazard;
    flush = !reset && !stall && branch_taken && ID_valid;
    PC_enable = !stall;
    ID_bubble = reset || stall || !ID_valid;
    state_nxt = stall ? STALL : RUN;
  end
  // FSM state register
  always_ff @(posedge clk)
    state <= reset ? RUN : state_nxt;
  // IF/ID register: hold on stall, squash the fetched word on flush
  always_ff @(posedge clk) begin
    if (reset) begin
      ID_instruction <= NOP_WORD;
      ID_PC <= '0;
      ID_valid <= 1'b0;
    end else if (!stall) begin
      ID_instruction <= flush ? NOP_WORD : IF_instruction;
      ID_PC <= IF_PC;
      ID_valid <= !flush;
    end
  end
  sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall), .count(stall_count)
  );
  sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush), .count(flush_count)
  );
endmodule

// File: tb/tb_if_id_pipeline_ctrl.sv
// tb_if_id_pipeline_ctrl: directed checks of the IF/ID register, stall, flush and counters
module tb_if_id_pipeline_ctrl;
  localparam int DW = 32;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic reset;
  logic [DW-1:0] IF_PC, IF_instruction, ID_instruction, ID_PC;
  logic [3:0] EXE_Rd_num;
  logic EXE_load_instr, EXE_RF_enable, branch_taken;
  logic ID_valid, PC_enable, ID_bubble;
  logic [CW-1:0] stall_count, flush_count;
  int total = 0;
  int passed = 0;

  if_id_pipeline_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .NOP_WORD(32'h0)) dut (
    .clk(clk), .reset(reset), .IF_PC(IF_PC), .IF_instruction(IF_instruction),
    .EXE_Rd_num(EXE_Rd_num), .EXE_load_instr(EXE_load_instr), .EXE_RF_enable(EXE_RF_enable),
    .branch_taken(branch_taken), .ID_instruction(ID_instruction), .ID_PC(ID_PC),
    .ID_valid(ID_valid), .PC_enable(PC_enable), .ID_bubble(ID_bubble),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; IF_PC = '0; IF_instruction = 32'hE0811002;
    EXE_Rd_num = 4'd0; EXE_load_instr = 1'b0; EXE_RF_enable = 1'b0; branch_taken = 1'b0;
    tick();
    total++; if (ID_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", ID_valid); else passed++;
    total++; if (ID_instruction !== 32'h0) $display("FAIL rst_instr got %h want 0", ID_instruction); else passed++;
    total++; if (stall_count !== 8'd0 || flush_count !== 8'd0) $display("FAIL rst_counts got %0d/%0d want 0/0", stall_count, flush_count); else passed++;
    total++; if (ID_bubble !== 1'b1 || PC_enable !== 1'b1) $display("FAIL rst_ctrl got bubble=%b pc_en=%b want 1/1", ID_bubble, PC_enable); else passed++;
    reset = 1'b0;
    tick();
    total++; if (ID_instruction !== 32'hE0811002 || ID_valid !== 1'b1) $display("FAIL first_fetch got %h v=%b want e0811002 v=1", ID_instruction, ID_valid); else passed++;
  endtask

  task automatic test_load_use();
    IF_instruction = 32'hE0822003; IF_PC = 32'h4;
    EXE_load_instr = 1'b1; EXE_RF_enable = 1'b1; EXE_Rd_num = 4'd2;
    #1;
    total++; if (PC_enable !== 1'b0 || ID_bubble !== 1'b1) $display("FAIL lu_stall got pc_en=%b bubble=%b want 0/1", PC_enable, ID_bubble); else passed++;
    tick();
    total++; if (ID_instruction !== 32'hE0811002) $display("FAIL lu_hold got %h want e0811002", ID_instruction); else passed++;
    total++; if (stall_count !== 8'd1) $display("FAIL lu_count got %0d want 1", stall_count); else passed++;
    #1;
    total++; if (PC_enable !== 1'b1 || ID_bubble !== 1'b0) $display("FAIL lu_release got pc_en=%b bubble=%b want 1/0", PC_enable, ID_bubble); else passed++;
    tick();
    total++; if (ID_instruction !== 32'hE0822003 || ID_PC !== 32'h4) $display("FAIL lu_advance got %h pc=%h want e0822003 pc=4", ID_instruction, ID_PC); else passed++;
    EXE_load_instr = 1'b0;
  endtask

  task automatic test_source_decode();
    IF_instruction = 32'hE2811005;
    tick();
    EXE_load_instr = 1'b1; EXE_Rd_num = 4'd5;
    #1;
    total++; if (PC_enable !== 1'b1 || ID_bubble !== 1'b0) $display("FAIL imm_rm got pc_en=%b bubble=%b want 1/0", PC_enable, ID_bubble); else passed++;
    EXE_Rd_num = 4'd1;
    #1;
    total++; if (PC_enable !== 1'b0) $display("FAIL imm_rn got pc_en=%b want 0", PC_enable); else passed++;
    EXE_load_instr = 1'b0; IF_instruction = 32'hE5812000;
    tick();
    EXE_load_instr = 1'b1; EXE_Rd_num = 4'd2;
    #1;
    total++; if (PC_enable !== 1'b0) $display("FAIL str_rd got pc_en=%b want 0", PC_enable); else passed++;
    EXE_load_instr = 1'b0; IF_instruction = 32'hE5912000;
    tick();
    EXE_load_instr = 1'b1;
    #1;
    total++; if (PC_enable !== 1'b1) $display("FAIL ldr_rd got pc_en=%b want 1", PC_enable); else passed++;
    EXE_load_instr = 1'b0;
    total++; if (stall_count !== 8'd1) $display("FAIL decode_count got %0d want 1", stall_count); else passed++;
  endtask

  task automatic test_branch_flush();
    branch_taken = 1'b1; IF_PC = 32'h40; IF_instruction = 32'hE1A00000;
    #1;
    total++; if (PC_enable !== 1'b1 || ID_bubble !== 1'b0) $display("FAIL br_ctrl got pc_en=%b bubble=%b want 1/0", PC_enable, ID_bubble); else passed++;
    tick();
    total++; if (ID_valid !== 1'b0 || ID_instruction !== 32'h0 || ID_PC !== 32'h40) $display("FAIL br_flush got v=%b %h pc=%h want v=0 0 pc=40", ID_valid, ID_instruction, ID_PC); else passed++;
    total++; if (flush_count !== 8'd1) $display("FAIL br_count got %0d want 1", flush_count); else passed++;
    branch_taken = 1'b0; IF_instruction = 32'hE3A01001; IF_PC = 32'h80;
    #1;
    total++; if (ID_bubble !== 1'b1) $display("FAIL br_bubble got %b want 1", ID_bubble); else passed++;
    tick();
    total++; if (ID_instruction !== 32'hE3A01001 || ID_valid !== 1'b1 || ID_PC !== 32'h80) $display("FAIL br_target got %h v=%b pc=%h want e3a01001 v=1 pc=80", ID_instruction, ID_valid, ID_PC); else passed++;
  endtask

  task automatic test_stall_vs_branch();
    IF_instruction = 32'hE0811002; IF_PC = 32'h84;
    tick();
    EXE_load_instr = 1'b1; EXE_Rd_num = 4'd2; branch_taken = 1'b1;
    IF_PC = 32'h88; IF_instruction = 32'hE1A00000;
    #1;
    total++; if (PC_enable !== 1'b0 || ID_bubble !== 1'b1) $display("FAIL sb_stall got pc_en=%b bubble=%b want 0/1", PC_enable, ID_bubble); else passed++;
    tick();
    total++; if (flush_count !== 8'd1 || stall_count !== 8'd2) $display("FAIL sb_counts got flush=%0d stall=%0d want 1/2", flush_count, stall_count); else passed++;
    total++; if (ID_instruction !== 32'hE0811002) $display("FAIL sb_hold got %h want e0811002", ID_instruction); else passed++;
    tick();
    total++; if (flush_count !== 8'd2 || ID_valid !== 1'b0 || ID_PC !== 32'h88) $display("FAIL sb_flush got flush=%0d v=%b pc=%h want 2 v=0 pc=88", flush_count, ID_valid, ID_PC); else passed++;
    branch_taken = 1'b0; EXE_load_instr = 1'b0; IF_instruction = 32'hE0811002;
    tick();
  endtask

  task automatic test_saturate_and_reset();
    EXE_load_instr = 1'b1; EXE_Rd_num = 4'd2;
    for (int i = 0; i < 600; i++) tick();
    total++; if (stall_count !== 8'hFF) $display("FAIL sat_value got %h want ff", stall_count); else passed++;
    #1;
    total++; if (PC_enable !== 1'b0) $display("FAIL sat_hazard got pc_en=%b want 0", PC_enable); else passed++;
    tick();
    total++; if (stall_count !== 8'hFF) $display("FAIL sat_hold got %h want ff", stall_count); else passed++;
    reset = 1'b1;
    tick();
    total++; if (stall_count !== 8'd0 || flush_count !== 8'd0 || ID_valid !== 1'b0 || ID_PC !== 32'h0) $display("FAIL stall_rst got s=%0d f=%0d v=%b pc=%h want 0 0 0 0", stall_count, flush_count, ID_valid, ID_PC); else passed++;
    reset = 1'b0;
    tick();
    total++; if (ID_instruction !== 32'hE0811002 || ID_valid !== 1'b1) $display("FAIL post_rst_fetch got %h v=%b want e0811002 v=1", ID_instruction, ID_valid); else passed++;
    #1;
    total++; if (PC_enable !== 1'b0) $display("FAIL post_rst_run got pc_en=%b want 0", PC_enable); else passed++;
    tick();
    total++; if (stall_count !== 8'd1) $display("FAIL post_rst_count got %0d want 1", stall_count); else passed++;
    EXE_load_instr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_source_decode();
    test_branch_flush();
    test_stall_vs_branch();
    test_saturate_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/if_id_pipeline_ctrl.md
Name: if_id_pipeline_ctrl

Overview:
IF/ID pipeline register plus the feedback control for the front of the pipeline. It latches the fetched instruction and PC for the ID stage. It consumes the EXE-stage destination/load/RF-enable signals that the ID/EXE register produces, detects load-use hazards, and drives PC/IF-ID hold and an ID/EXE bubble request back upstream. It also handles the flush on a taken branch and keeps saturating stall and flush counters for performance debug.

Parameters:
DATA_WIDTH, 32, width of the instruction and PC.
COUNT_WIDTH, 16, width of each saturating event counter.
NOP_WORD, 32'h0000_0000, instruction value loaded into ID on reset or flush.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
IF_PC  input  DATA_WIDTH  PC of the fetched instruction.
IF_instruction  input  DATA_WIDTH  fetched instruction word.
EXE_Rd_num  input  4  destination register of the instruction in EXE.
EXE_load_instr  input  1  instruction in EXE is a load.
EXE_RF_enable  input  1  instruction in EXE writes the register file.
branch_taken  input  1  ID-stage branch resolved taken (condition true).
ID_instruction  output  DATA_WIDTH  registered instruction for ID.
ID_PC  output  DATA_WIDTH  registered PC for ID.
ID_valid  output  1  ID holds a real instruction.
PC_enable  output  1  PC may advance.
ID_bubble  output  1  ID/EXE must load zeroed controls this cycle.
stall_count  output  COUNT_WIDTH  load-use stalls taken.
flush_count  output  COUNT_WIDTH  branch flushes taken.

Behaviour:
- Reset (sync, active-high; wins over everything): ID_instruction=NOP_WORD, ID_PC=0, ID_valid=0, state=RUN, both counters=0. During the reset cycle: PC_enable=1, ID_bubble=1.
- Source-register use, decoded from ID_instruction:
  - Rn=[19:16] is used unless [27:25]==3'b101 (branch).
  - Rm=[3:0] is used when [27:25]==3'b000 or 3'b011.
  - Rd=[15:12] is used as a source when [27:26]==2'b01 and [20]==0 (store).
- hazard = ID_valid && EXE_load_instr && EXE_RF_enable && (EXE_Rd_num matches any used source). Combinational.
- Two-state FSM:
  - RUN, hazard=1: PC_enable=0, ID_bubble=1, IF/ID registers hold their values, stall_count++, next state=STALL.
  - RUN, hazard=0 and branch_taken=1 (with ID_valid=1): PC_enable=1, ID_bubble=0, ID_instruction<=NOP_WORD, ID_valid<=0, ID_PC<=IF_PC, flush_count++, state stays RUN.
  - RUN, otherwise: PC_enable=1, ID_bubble=!ID_valid, ID_instruction<=IF_instruction, ID_PC<=IF_PC, ID_valid<=1.
  - STALL: hazard is masked. EXE now holds the bubble; the loaded value reaches ID through MEM forwarding. Normal RUN advance/flush rules apply. Next state=RUN.
- Stall has priority over branch_taken in the same cycle. The branch re-evaluates after the stall.
- Counters saturate at all-ones and do not wrap.
- Latency: one cycle from IF to ID. Each load-use stall adds exactly one cycle. Each flush discards exactly one fetched instruction.
- Reset asserted while in STALL returns to RUN with the reset values above. No partial hold survives reset.

Decomposition:
- Shared package:
  - I_cmd field constants (3'b000, 3'b001, 3'b011, 3'b101).
  - Bit-position constants for Rn, Rm, Rd, L and S.
  - FSM state encoding (RUN=0, STALL=1).
  - NOP_WORD.
- One natural sub-module: sat_counter (COUNT_WIDTH, inc, reset), instantiated twice.

Test Plan:
1. Reset with IF_instruction=32'hE0811002: ID_valid=0, ID_instruction=0, counters=0, ID_bubble=1. One cycle after reset deasserts, ID_instruction=32'hE0811002 and ID_valid=1.
2. Load-use stall: ID holds ADD r1,r1,r2 (32'hE0811002); EXE_load_instr=1, EXE_RF_enable=1, EXE_Rd_num=2. Required: PC_enable=0 and ID_bubble=1 for exactly one cycle, ID_instruction held, stall_count=1. Next cycle advances even if EXE signals are unchanged.
3. Immediate form 32'hE2811005 (Rm field = 5) with EXE_Rd_num=5 and load active: no stall, because Rm is unused.
4. Branch flush: branch_taken=1 with IF_PC=0x40. Next cycle ID_valid=0, ID_instruction=0, ID_PC=0x40, flush_count=1. The following cycle loads the fetched target.
5. Simultaneous hazard and branch_taken: the stall occurs and flush_count stays 0. After the stall, branch_taken=1 flushes, giving flush_count=1.
6. Force 65535 stalls then one more: stall_count stays 16'hFFFF. Reset mid-STALL: state=RUN and counters=0 the next cycle.
